// File: rtl/adder_arb_pkg.sv
// Shared definitions for the shared-adder arbiter (states, limits, counter width).
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned PERF_CNT_W = 16;

endpackage : adder_arb_pkg

// File: rtl/adder_share_arb_if.sv
// Requester / adder / response bus of the shared-adder arbiter.
// slave: arbiter side; master: requesters, adder and response consumer.
interface adder_share_arb_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_op1;
  logic [NUM_REQ*WIDTH-1:0] req_op2;
  logic [NUM_REQ-1:0]       req_cin;

  logic [WIDTH-1:0]         add_op1;
  logic [WIDTH-1:0]         add_op2;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_sum;
  logic                     resp_cout;

  modport slave (
    input  req_valid, req_op1, req_op2, req_cin, add_sum, add_cout, resp_ready,
    output req_ready, add_op1, add_op2, add_cin, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport master (
    output req_valid, req_op1, req_op2, req_cin, add_sum, add_cout, resp_ready,
    input  req_ready, add_op1, add_op2, add_cin, resp_valid, resp_id, resp_sum, resp_cout
  );

endinterface : adder_share_arb_if

// File: rtl/adder_share_arb_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching from ptr+1
// upward with wrap at N. Returns one-hot grant and its encoded index.
module rr_picker #(
  parameter int unsigned N = 3,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_c,
  output logic [ID_W-1:0] id_c
);

  // Walk from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    int unsigned s;
    gnt_c = '0;
    id_c  = '0;
    s     = 0;
    for (int unsigned i = N; i >= 1; i--) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      if (req[ID_W'(s)]) begin
        gnt_c              = '0;
        gnt_c[ID_W'(s)]    = 1'b1;
        id_c               = ID_W'(s);
      end
    end
  end

endmodule : rr_picker

// File: rtl/adder_share_arb.sv
// Shares one external adder between NUM_REQ requesters: round-robin grant,
// registered operands, captured sum/carry, tagged response held until accepted.
// Optional build macro ADDER_ARB_PERF_EN adds per-requester 16-bit grant counters.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned WIDTH   = 32,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef ADDER_ARB_PERF_EN
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grants,
`endif
  adder_share_arb_if.slave              bus
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [WIDTH-1:0]    add_op1_q, add_op1_d;
  logic [WIDTH-1:0]    add_op2_q, add_op2_d;
  logic                add_cin_q, add_cin_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [WIDTH-1:0]    resp_sum_q, resp_sum_d;
  logic                resp_cout_q, resp_cout_d;

  logic [NUM_REQ-1:0]  pick_gnt_c;
  logic [ID_W-1:0]     pick_id_c;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic                hs_c;
  logic [WIDTH-1:0]    op1_sel_c, op2_sel_c;
  logic                cin_sel_c;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .gnt_c (pick_gnt_c),
    .id_c  (pick_id_c)
  );

  // Operand mux for the requester the picker selected.
  always_comb begin
    op1_sel_c = '0;
    op2_sel_c = '0;
    cin_sel_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_id_c == ID_W'(i)) begin
        op1_sel_c = bus.req_op1[i*WIDTH +: WIDTH];
        op2_sel_c = bus.req_op2[i*WIDTH +: WIDTH];
        cin_sel_c = bus.req_cin[i];
      end
    end
  end

  // Next-state and datapath update for IDLE -> CALC -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    add_op1_d    = add_op1_q;
    add_op2_d    = add_op2_q;
    add_cin_d    = add_cin_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    req_ready_c  = '0;
    hs_c         = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_c = pick_gnt_c;
        hs_c        = |(bus.req_valid & req_ready_c);
        if (hs_c) begin
          add_op1_d = op1_sel_c;
          add_op2_d = op2_sel_c;
          add_cin_d = cin_sel_c;
          id_d      = pick_id_c;
          rr_ptr_d  = pick_id_c;
          state_d   = CALC;
        end
      end
      CALC: begin
        resp_sum_d   = bus.add_sum;
        resp_cout_d  = bus.add_cout;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      add_op1_q    <= '0;
      add_op2_q    <= '0;
      add_cin_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      add_op1_q    <= add_op1_d;
      add_op2_q    <= add_op2_d;
      add_cin_q    <= add_cin_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.add_op1    = add_op1_q;
  assign bus.add_op2    = add_op2_q;
  assign bus.add_cin    = add_cin_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_cout  = resp_cout_q;

`ifdef ADDER_ARB_PERF_EN
  logic [NUM_REQ-1:0][PERF_CNT_W-1:0] perf_q, perf_d;

  // Count handshakes per requester; counters wrap naturally.
  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (hs_c && (pick_id_c == ID_W'(i))) perf_d[i] = perf_q[i] + PERF_CNT_W'(1);
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_grants = perf_q;
`endif

endmodule : adder_share_arb
